pipe_ctrl: RTL and testbench

//  Pipeline control unit for the 5-stage core. Merges stall requests from ID, EX (multi-cycle
//  div/madd) and MEM (bus wait) into the 6-bit stall vector consumed by pc_reg, if_id, id_ex,
//  ex_mem and mem_wb, and sequences exception/eret flushes with the restart PC.

---
 rtl/pipe_ctrl_if.sv | 26 ++
 rtl/pipe_ctrl.sv | 116 +++++++++++
 tb/tb_pipe_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Stall/flush bundle between the pipeline stages and pipe_ctrl.
// The stages drive the master side; pipe_ctrl is the slave.
interface pipe_ctrl_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles_o;
    logic        stall_timeout_o;

    modport master (
        output stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        output excepttype_i, cp0_epc_i,
        input  stall, flush, new_pc, stall_cycles_o, stall_timeout_o
    );

    modport slave (
        input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        input  excepttype_i, cp0_epc_i,
        output stall, flush, new_pc, stall_cycles_o, stall_timeout_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stage stall requests, sequences exception/eret flushes.
// Optional stall watchdog enabled by defining STALL_WDT_EN.
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [31:0] EXC_VECTOR   = 32'h00000040,
    parameter logic [31:0] INT_VECTOR   = 32'h00000020,
    parameter int unsigned WDT_LIMIT    = 1024
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic {S_RUN, S_FLUSH} state_t;

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || WDT_LIMIT < 1 || WDT_LIMIT > 65535) begin : g_bad_param
        $error("pipe_ctrl: illegal FLUSH_CYCLES or WDT_LIMIT");
    end

    state_t      r_state;
    logic [3:0]  r_flush_cnt;
    logic [31:0] r_new_pc;
    logic [31:0] r_stall_cycles;

    logic        w_run;
    logic        w_exc;
    logic        w_in_flush;
    logic        w_flush;
    logic [5:0]  w_stall;
    logic [31:0] w_exc_pc;

    // Outputs are gated by rst so an asserted reset forces the idle values at once.
    assign w_run      = rst && (r_state == S_RUN);
    assign w_in_flush = rst && (r_state == S_FLUSH);
    assign w_exc      = w_run && (|bus.excepttype_i);
    assign w_flush    = w_exc || w_in_flush;

    always_comb begin
        w_stall = 6'b000000;
        if (w_run && !w_exc) begin
            if (bus.stallreq_from_mem)     w_stall = 6'b011111;
            else if (bus.stallreq_from_ex) w_stall = 6'b001111;
            else if (bus.stallreq_from_id) w_stall = 6'b000111;
        end
    end

    always_comb begin
        w_exc_pc = EXC_VECTOR;
        case (bus.excepttype_i)
            32'h0000_0001: w_exc_pc = INT_VECTOR;
            32'h0000_000e: w_exc_pc = bus.cp0_epc_i;
            32'h0000_0008, 32'h0000_000a,
            32'h0000_000c, 32'h0000_000d: w_exc_pc = EXC_VECTOR;
            default:       w_exc_pc = EXC_VECTOR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_RUN;
            r_flush_cnt <= 4'd0;
            r_new_pc    <= 32'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_exc) begin
                        r_new_pc <= w_exc_pc;
                        if (FLUSH_CYCLES > 1) begin
                            r_state     <= S_FLUSH;
                            r_flush_cnt <= 4'(FLUSH_CYCLES - 1);
                        end
                    end
                end
                S_FLUSH: begin
                    // The cycle that raised the exception already counted as one flush cycle.
                    if (r_flush_cnt == 4'd1) r_state <= S_RUN;
                    r_flush_cnt <= r_flush_cnt - 4'd1;
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_stall_cycles <= 32'd0;
        else if (|w_stall)  r_stall_cycles <= r_stall_cycles + 32'd1;
    end

    assign bus.stall          = w_stall;
    assign bus.flush          = w_flush;
    assign bus.new_pc         = w_exc ? w_exc_pc : (w_in_flush ? r_new_pc : 32'd0);
    assign bus.stall_cycles_o = r_stall_cycles;

`ifdef STALL_WDT_EN
    localparam logic [15:0] LP_WDT_LIMIT = 16'(WDT_LIMIT);

    logic [15:0] r_wdt_cnt;
    logic        r_timeout;

    // Counter saturates at the limit; the flag is sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdt_cnt <= 16'd0;
            r_timeout <= 1'b0;
        end else if (!(|w_stall) || w_flush) begin
            r_wdt_cnt <= 16'd0;
        end else if (r_wdt_cnt != LP_WDT_LIMIT) begin
            r_wdt_cnt <= r_wdt_cnt + 16'd1;
            if (r_wdt_cnt == LP_WDT_LIMIT - 16'd1) r_timeout <= 1'b1;
        end
    end

    assign bus.stall_timeout_o = r_timeout;
`else
    assign bus.stall_timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: scoreboard of expected stall/flush/new_pc per cycle.
// Watchdog section is compiled only when STALL_WDT_EN is defined.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if if1 ();
    pipe_ctrl_if if3 ();

    pipe_ctrl #(.FLUSH_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    pipe_ctrl #(.FLUSH_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

`ifdef STALL_WDT_EN
    pipe_ctrl_if ifw ();
    pipe_ctrl #(.WDT_LIMIT(4)) dutw (.clk(clk), .rst(rst), .bus(ifw.slave));
`endif

    typedef struct {
        int          dut;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] m_cyc1  = 32'd0;
    logic [31:0] m_cyc3  = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp_v);
    endtask

    task automatic idle_all();
        if1.stallreq_from_id = 0; if1.stallreq_from_ex = 0; if1.stallreq_from_mem = 0;
        if1.excepttype_i = 0; if1.cp0_epc_i = 0;
        if3.stallreq_from_id = 0; if3.stallreq_from_ex = 0; if3.stallreq_from_mem = 0;
        if3.excepttype_i = 0; if3.cp0_epc_i = 0;
`ifdef STALL_WDT_EN
        ifw.stallreq_from_id = 0; ifw.stallreq_from_ex = 0; ifw.stallreq_from_mem = 0;
        ifw.excepttype_i = 0; ifw.cp0_epc_i = 0;
`endif
    endtask

    // One cycle: drive at negedge, check combinational outputs, then take the edge.
    task automatic cyc(input string tag, input int dut, input logic id, input logic ex,
                       input logic mem, input logic [31:0] exc, input logic [31:0] epc,
                       input logic [5:0] es, input logic ef, input logic [31:0] ep);
        exp_t e;
        if (dut == 1) begin
            if1.stallreq_from_id = id; if1.stallreq_from_ex = ex; if1.stallreq_from_mem = mem;
            if1.excepttype_i = exc; if1.cp0_epc_i = epc;
        end else begin
            if3.stallreq_from_id = id; if3.stallreq_from_ex = ex; if3.stallreq_from_mem = mem;
            if3.excepttype_i = exc; if3.cp0_epc_i = epc;
        end
        sb.push_back('{dut, es, ef, ep});
        #1;
        e = sb.pop_front();
        if (e.dut == 1) begin
            chk({tag, ".stall"},  32'(if1.stall), 32'(e.stall));
            chk({tag, ".flush"},  32'(if1.flush), 32'(e.flush));
            chk({tag, ".new_pc"}, if1.new_pc, e.pc);
            chk({tag, ".cycles"}, if1.stall_cycles_o, m_cyc1);
        end else begin
            chk({tag, ".stall"},  32'(if3.stall), 32'(e.stall));
            chk({tag, ".flush"},  32'(if3.flush), 32'(e.flush));
            chk({tag, ".new_pc"}, if3.new_pc, e.pc);
            chk({tag, ".cycles"}, if3.stall_cycles_o, m_cyc3);
        end
        @(posedge clk);
        if (e.stall != 6'b0) begin
            if (e.dut == 1) m_cyc1 = m_cyc1 + 32'd1;
            else            m_cyc3 = m_cyc3 + 32'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        idle_all();
        repeat (3) @(negedge clk);
        chk("rst.stall",  32'(if1.stall), 32'd0);
        chk("rst.flush",  32'(if1.flush), 32'd0);
        chk("rst.new_pc", if1.new_pc, 32'd0);
        chk("rst.cycles", if1.stall_cycles_o, 32'd0);
        chk("rst.tmo",    32'(if1.stall_timeout_o), 32'd0);
        rst = 1'b1;

        // Stall priority and merging
        cyc("idle",     1, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0);
        cyc("all3",     1, 1, 1, 1, 32'h0, 32'h0, 6'b011111, 0, 32'h0);
        cyc("id_ex",    1, 1, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0);
        cyc("id",       1, 1, 0, 0, 32'h0, 32'h0, 6'b000111, 0, 32'h0);
        cyc("mem",      1, 0, 0, 1, 32'h0, 32'h0, 6'b011111, 0, 32'h0);

        // Exceptions with single-cycle flush
        cyc("int",      1, 0, 1, 0, 32'h1, 32'h0, 6'b000000, 1, 32'h20);
        cyc("int_post", 1, 0, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0);
        cyc("sys",      1, 1, 1, 1, 32'h8, 32'h0, 6'b000000, 1, 32'h40);
        cyc("inv",      1, 0, 0, 0, 32'ha, 32'h0, 6'b000000, 1, 32'h40);
        cyc("trap",     1, 0, 0, 0, 32'hc, 32'h0, 6'b000000, 1, 32'h40);
        cyc("ovf",      1, 0, 0, 0, 32'hd, 32'h0, 6'b000000, 1, 32'h40);
        cyc("other",    1, 0, 0, 0, 32'h55, 32'h0, 6'b000000, 1, 32'h40);
        cyc("eret",     1, 1, 0, 0, 32'he, 32'habc, 6'b000000, 1, 32'habc);
        cyc("post",     1, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0);

        // Stall counter wrap
        force dut1.r_stall_cycles = 32'hFFFFFFFE;
        #1;
        release dut1.r_stall_cycles;
        m_cyc1 = 32'hFFFFFFFE;
        cyc("wrap0",    1, 1, 0, 0, 32'h0, 32'h0, 6'b000111, 0, 32'h0);
        cyc("wrap1",    1, 1, 0, 0, 32'h0, 32'h0, 6'b000111, 0, 32'h0);
        cyc("wrap2",    1, 1, 0, 0, 32'h0, 32'h0, 6'b000111, 0, 32'h0);
        cyc("wrap3",    1, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0);
        idle_all();

        // Three-cycle flush: latched eret target, inputs ignored while flushing
        cyc("f3.a",     3, 0, 1, 0, 32'he, 32'h1234, 6'b000000, 1, 32'h1234);
        cyc("f3.b",     3, 0, 1, 0, 32'h0, 32'h5678, 6'b000000, 1, 32'h1234);
        cyc("f3.c",     3, 1, 1, 1, 32'h0, 32'h9999, 6'b000000, 1, 32'h1234);
        cyc("f3.d",     3, 0, 1, 0, 32'h0, 32'h0,    6'b001111, 0, 32'h0);
        cyc("f3.int",   3, 0, 0, 0, 32'h1, 32'h0,    6'b000000, 1, 32'h20);
        cyc("f3.ign",   3, 0, 0, 0, 32'h8, 32'h0,    6'b000000, 1, 32'h20);
        cyc("f3.end",   3, 0, 0, 0, 32'h0, 32'h0,    6'b000000, 1, 32'h20);
        cyc("f3.run",   3, 0, 0, 0, 32'h0, 32'h0,    6'b000000, 0, 32'h0);

        // Async reset in the middle of a flush
        cyc("rf.a",     3, 0, 0, 0, 32'h8, 32'h0,    6'b000000, 1, 32'h40);
        if3.excepttype_i = 32'h0;
        #1;
        chk("rf.inflush", 32'(if3.flush), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rf.flush",  32'(if3.flush), 32'd0);
        chk("rf.new_pc", if3.new_pc, 32'd0);
        chk("rf.cyc1",   if1.stall_cycles_o, 32'd0);
        m_cyc1 = 32'd0;
        m_cyc3 = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        cyc("rf.run",   3, 0, 1, 0, 32'h0, 32'h0,    6'b001111, 0, 32'h0);
        idle_all();

`ifdef STALL_WDT_EN
        ifw.stallreq_from_ex = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("wdt.run1", 32'(ifw.stall_timeout_o), 32'd0);
        end
        ifw.stallreq_from_ex = 0;
        @(posedge clk); #1;
        ifw.stallreq_from_ex = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("wdt.run2", 32'(ifw.stall_timeout_o), 32'd0);
        end
        @(posedge clk); #1;
        chk("wdt.rise", 32'(ifw.stall_timeout_o), 32'd1);
        ifw.stallreq_from_ex = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("wdt.hold", 32'(ifw.stall_timeout_o), 32'd1);
        rst = 1'b0;
        #1;
        chk("wdt.clr", 32'(ifw.stall_timeout_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
`else
        if1.stallreq_from_mem = 1;
        repeat (5) @(posedge clk);
        #1;
        chk("tmo.tied", 32'(if1.stall_timeout_o), 32'd0);
        if1.stallreq_from_mem = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running want finished");
        $fatal(1, "timeout");
    end
endmodule
